// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// UartRx: 8N1 serial receiver with a small receive FIFO.
//
// The incoming line is double-flopped, then a five-state FSM times each bit
// from a bit-period down-counter. It samples mid-bit and assembles bytes
// LSB first. Finished bytes land in a DEPTH-entry circular FIFO that the
// consumer drains with ack.
//
// Ports:
//   clk_i      - system clock, all state changes on its rising edge
//   reset_i    - asynchronous active-high reset
//   prescaler  - bit period minus one, in clk_i cycles
//   rx         - asynchronous serial input, idle high
//   data       - FIFO head byte, meaningful only while have_next is high
//   have_next  - FIFO holds at least one byte
//   ack        - pop the head byte (ignored when the FIFO is empty)
//   frame_err  - one-cycle pulse when a stop bit is sampled low
//   overrun    - one-cycle pulse when a finished byte is lost to a full FIFO
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] prescaler,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        have_next,
    input  logic        ack,
    output logic        frame_err,
    output logic        overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Fixed encodings let debug tools and benches name states by value.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        rxMeta_q, rxSync_q;
    logic        frameErr_q, frameErr_d;
    logic        overrun_q;
    logic        push, pop, full, pushOk;
    logic [AW:0] wrPtr_q, rdPtr_q;
    logic [7:0]  mem [DEPTH];

    // Two-flop synchronizer. It resets to the idle level so that reset
    // release never looks like a start bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= push & full & ~pop;
        end
    end

    // Bit-timing FSM. The start bit is checked half a period after the
    // falling edge. Every later sample happens one full period after the
    // previous one. push is raised for exactly the stop-sample cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frameErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxSync_q) begin
                    cnt_d   = prescaler >> 1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (!rxSync_q) begin
                    cnt_d   = prescaler;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    shift_d = {rxSync_q, shift_q[7:1]};
                    cnt_d   = prescaler;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (rxSync_q) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    frameErr_d = 1'b1;
                    state_d    = BREAK;
                end
            end
            BREAK: begin
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The extra pointer MSB tells full apart from empty. When the FIFO is
    // full and a pop happens in the same cycle, the write reuses the slot
    // that is being freed.
    assign have_next = (wrPtr_q != rdPtr_q);
    assign full      = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) &&
                       (wrPtr_q[AW] != rdPtr_q[AW]);
    assign pop       = ack & have_next;
    assign pushOk    = push & (~full | pop);
    assign data      = mem[rdPtr_q[AW-1:0]];
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;

    // FIFO pointers. Reset clears them, which discards any stored bytes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
        end
    end

    // FIFO storage. It needs no reset because the pointers decide validity.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem[wrPtr_q[AW-1:0]] <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx: directed bench for uart_rx (DEPTH = 4).
// Inputs change only on falling clock edges. Outputs are checked on falling
// edges. frame_err and overrun pulses are counted on rising edges so that
// each test can check how many pulses occurred.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] prescaler;
    logic        rx;
    logic [7:0]  data;
    logic        have_next;
    logic        ack;
    logic        frame_err;
    logic        overrun;

    int compared   = 0;
    int mismatched = 0;
    int feCount    = 0;
    int ovCount    = 0;
    int feBase;
    int ovBase;

    uart_rx #(.DEPTH(4)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .prescaler (prescaler),
        .rx        (rx),
        .data      (data),
        .have_next (have_next),
        .ack       (ack),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // 10 ns system clock.
    always #5 clk_i = ~clk_i;

    // Pulse counters. The registered pulses are stable across a rising edge,
    // so a pulse that stays high for two cycles is counted twice.
    always @(posedge clk_i) begin
        if (frame_err) feCount++;
        if (overrun)   ovCount++;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one 8N1 frame at the current prescaler. The task is called on a
    // falling edge and returns on the falling edge just after the last
    // stop-bit cycle. With prescaler=3, that edge is just before the rising
    // edge on which the stop bit is sampled.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        int n;
        n = int'(prescaler) + 1;
        rx = 1'b0;
        repeat (n) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (n) @(negedge clk_i);
        end
        rx = stopBit;
        repeat (n) @(negedge clk_i);
        rx = 1'b1;
    endtask

    // Check the head byte, then pop it with a one-cycle ack.
    task automatic popAndCheck(input string tag, input logic [7:0] exp);
        checkOutput({tag, "_have"}, 32'(have_next), 32'd1);
        checkOutput({tag, "_data"}, 32'(data), 32'(exp));
        ack = 1'b1;
        @(negedge clk_i);
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] partial;

        reset_i   = 1'b1;
        rx        = 1'b1;
        ack       = 1'b0;
        prescaler = 32'd3;
        repeat (3) @(negedge clk_i);

        // Reset state.
        checkOutput("rst_have", 32'(have_next), 32'd0);
        checkOutput("rst_ferr", 32'(frame_err), 32'd0);
        checkOutput("rst_ovr",  32'(overrun),   32'd0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Single byte 0xA5 with one-cycle latency after the stop sample.
        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_before_stop", 32'(have_next), 32'd0);
        @(negedge clk_i);
        popAndCheck("a5", 8'hA5);
        checkOutput("a5_empty", 32'(have_next), 32'd0);

        // Five back-to-back bytes with no ack: the fifth is dropped.
        $display("[TB] overrun on fifth byte");
        ovBase = ovCount;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1);
        end
        repeat (4) @(negedge clk_i);
        checkOutput("ovr_count", 32'(ovCount - ovBase), 32'd1);
        popAndCheck("ovr_b1", 8'h01);
        popAndCheck("ovr_b2", 8'h02);
        popAndCheck("ovr_b3", 8'h03);
        popAndCheck("ovr_b4", 8'h04);
        checkOutput("ovr_empty", 32'(have_next), 32'd0);

        // Framing error followed by a break, then recovery.
        $display("[TB] framing error and break");
        prescaler = 32'd7;
        feBase = feCount;
        applyStimulus(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (20) @(negedge clk_i);
        checkOutput("fe_count", 32'(feCount - feBase), 32'd1);
        checkOutput("fe_have", 32'(have_next), 32'd0);
        checkOutput("fe_break", 32'(dut.state_q), 32'(ST_BREAK));
        rx = 1'b1;
        repeat (4) @(negedge clk_i);
        checkOutput("fe_idle", 32'(dut.state_q), 32'(ST_IDLE));
        applyStimulus(8'h55, 1'b1);
        repeat (2) @(negedge clk_i);
        popAndCheck("fe_next", 8'h55);

        // A 2-cycle glitch on the idle line is rejected as a false start.
        $display("[TB] glitch rejection");
        feBase = feCount;
        ovBase = ovCount;
        rx = 1'b0;
        repeat (2) @(negedge clk_i);
        rx = 1'b1;
        repeat (20) @(negedge clk_i);
        checkOutput("gl_have", 32'(have_next), 32'd0);
        checkOutput("gl_state", 32'(dut.state_q), 32'(ST_IDLE));
        checkOutput("gl_flags", 32'((feCount - feBase) + (ovCount - ovBase)), 32'd0);

        // FIFO full, with ack in the stop-sample cycle of 0x77.
        $display("[TB] simultaneous push and pop when full");
        prescaler = 32'd3;
        ovBase = ovCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1);
        end
        applyStimulus(8'h77, 1'b1);
        checkOutput("full_head", 32'(data), 32'h10);
        ack = 1'b1;
        @(negedge clk_i);
        ack = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("full_no_ovr", 32'(ovCount - ovBase), 32'd0);
        popAndCheck("full_b1", 8'h11);
        popAndCheck("full_b2", 8'h12);
        popAndCheck("full_b3", 8'h13);
        popAndCheck("full_b4", 8'h77);
        checkOutput("full_empty", 32'(have_next), 32'd0);

        // Reset while receiving the data bits of 0x81, then receive 0x42.
        $display("[TB] reset mid-frame");
        partial = 8'h81;
        rx = 1'b0;
        repeat (4) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            repeat (4) @(negedge clk_i);
        end
        checkOutput("mid_in_data", 32'(dut.state_q), 32'(ST_DATA));
        reset_i = 1'b1;
        rx = 1'b1;
        @(negedge clk_i);
        checkOutput("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        checkOutput("mid_rst_have", 32'(have_next), 32'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (10) @(negedge clk_i);
        checkOutput("mid_after_have", 32'(have_next), 32'd0);
        applyStimulus(8'h42, 1'b1);
        repeat (2) @(negedge clk_i);
        popAndCheck("mid_b42", 8'h42);
        checkOutput("mid_empty", 32'(have_next), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, receive-FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port prescaler  input  32  bit period N = prescaler+1 clk_i cycles; held stable while a frame is in progress.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-006 SHALL have port data  output  8  oldest received byte (FIFO head); valid only while have_next=1.
REQ-007 SHALL have port have_next  output  1  FIFO non-empty.
REQ-008 SHALL have port ack  input  1  consumer pop request for the head byte.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because the FIFO was full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer reset to 1; all following references to rx mean the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK, with a down-counter cnt[31:0] and a bit index idx[2:0].
REQ-013 IDLE: rx=0 -> cnt=prescaler>>1, go START; otherwise stay.
REQ-014 START: cnt>0 -> decrement; cnt=0 and rx=0 -> cnt=prescaler, idx=0, go DATA; cnt=0 and rx=1 -> false start, go IDLE, no flag.
REQ-015 DATA: at cnt=0 SHALL shift rx into shift-register bit 7 (shift right), reload cnt=prescaler, idx+1; after the sample with idx=7 go STOP.
REQ-016 STOP: at cnt=0 with rx=1 SHALL push the shift register into the FIFO and go IDLE; with rx=0 SHALL pulse frame_err, discard the byte, go BREAK.
REQ-017 BREAK: stay until rx=1, then go IDLE.
REQ-018 Sampling SHALL occur N/2 (floor((N-1)/2)) cycles after detected start, then every N cycles; prescaler=0 SHALL sample on every cycle.
REQ-019 The pushed byte SHALL be visible on data/have_next the cycle after the stop-bit sample (1-cycle latency).
REQ-020 FIFO SHALL be a DEPTH-entry circular buffer; read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-021 ack with have_next=1 SHALL pop the head at that clock edge; ack with have_next=0 SHALL be ignored.
REQ-022 A push while full SHALL drop the byte and pulse overrun, unless a valid ack occurs in the same cycle; then both pop and push SHALL succeed with no overrun.
REQ-023 A push and pop in the same cycle on a non-full FIFO SHALL leave occupancy unchanged.
REQ-024 data SHALL be the combinational head-entry read; its value when empty is don't-care.

Reset
REQ-025 While reset_i=1: FSM=IDLE, cnt=0, idx=0, shift register=0, synchronizer=1, pointers/occupancy=0, have_next=0, frame_err=0, overrun=0.
REQ-026 Reset mid-frame SHALL abandon the partial byte; after release the block SHALL wait for a new falling edge in IDLE.
REQ-027 FIFO contents SHALL be discarded on reset; storage RAM itself need not be cleared.

Verification
REQ-028 prescaler=3; drive frame for 0xA5 -> data=0xA5 with have_next=1 one cycle after stop sample; ack -> have_next=0.
REQ-029 prescaler=3; 5 back-to-back bytes 0x01..0x05 with no ack -> one overrun pulse on the 5th; acks return 0x01,0x02,0x03,0x04.
REQ-030 prescaler=7; frame 0x3C with stop bit low, rx held low 20 cycles -> one frame_err pulse, have_next stays 0, FSM in BREAK until rx high; the next good frame 0x55 is received.
REQ-031 prescaler=7; 2-cycle low glitch on idle rx -> no byte, no flags, FSM back in IDLE.
REQ-032 prescaler=3; FIFO full, ack asserted in the stop-sample cycle of 0x77 -> no overrun; 0x77 becomes the last entry.
REQ-033 Assert reset_i during DATA of byte 0x81, release, then send 0x42 -> only 0x42 is received.
